// File: rtl/mips_alu_seq.sv
// Handshaked MIPS ALU: single-cycle ops plus an iterative (or barrel) shifter.
// One transaction in flight; results are held in DONE until the consumer takes them.
module mips_alu_seq #(
  parameter int WIDTH      = 32,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      input_instruction,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  state_t           state;
  shift_t           sh_kind, sh_kind_q;
  logic [WIDTH-1:0] shreg, shift_next;
  logic [4:0]       cnt;

  logic [5:0]       opcode, funct;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] sext, zext;
  logic [WIDTH-1:0] sum_rr, diff_rr, sum_ri;
  logic [WIDTH-1:0] calc_result;
  logic             calc_ovf, calc_err, is_shift, iterate, accept;
  logic             unused_fields;

  assign opcode = input_instruction[31:26];
  assign funct  = input_instruction[5:0];
  assign shamt  = input_instruction[10:6];
  assign imm    = input_instruction[15:0];
  assign sext   = {{(WIDTH-16){imm[15]}}, imm};
  assign zext   = {{(WIDTH-16){1'b0}}, imm};
  // Register specifiers are resolved upstream; only operand contents arrive here.
  assign unused_fields = ^input_instruction[25:16];

  assign sum_rr  = rs_content + rt_content;
  assign diff_rr = rs_content - rt_content;
  assign sum_ri  = rs_content + sext;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    calc_result = '0;
    calc_ovf    = 1'b0;
    calc_err    = 1'b0;
    is_shift    = 1'b0;
    sh_kind     = SH_LL;
    if (opcode == 6'd0) begin
      case (funct)
        6'd32: begin
          calc_result = sum_rr;
          calc_ovf    = (rs_content[WIDTH-1] == rt_content[WIDTH-1]) &&
                        (sum_rr[WIDTH-1] != rs_content[WIDTH-1]);
        end
        6'd34: begin
          calc_result = diff_rr;
          calc_ovf    = (rs_content[WIDTH-1] != rt_content[WIDTH-1]) &&
                        (diff_rr[WIDTH-1] != rs_content[WIDTH-1]);
        end
        6'd36: calc_result = rs_content & rt_content;
        6'd37: calc_result = rs_content | rt_content;
        6'd42: calc_result = WIDTH'($signed(rs_content) < $signed(rt_content));
        6'd43: calc_result = WIDTH'(rs_content < rt_content);
        6'd0: begin
          is_shift    = 1'b1;
          sh_kind     = SH_LL;
          calc_result = rt_content << shamt;
        end
        6'd2: begin
          is_shift    = 1'b1;
          sh_kind     = SH_RL;
          calc_result = rt_content >> shamt;
        end
        6'd3: begin
          is_shift    = 1'b1;
          sh_kind     = SH_RA;
          calc_result = $unsigned($signed(rt_content) >>> shamt);
        end
        default: calc_err = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'd8: begin
          calc_result = sum_ri;
          calc_ovf    = (rs_content[WIDTH-1] == sext[WIDTH-1]) &&
                        (sum_ri[WIDTH-1] != rs_content[WIDTH-1]);
        end
        6'd9:  calc_result = sum_ri;
        6'd10: calc_result = WIDTH'($signed(rs_content) < $signed(sext));
        6'd11: calc_result = WIDTH'(rs_content < sext);
        6'd12: calc_result = rs_content & zext;
        6'd13: calc_result = rs_content | zext;
        6'd15: calc_result = zext << 16;
        default: calc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (sh_kind_q)
      SH_LL:   shift_next = shreg << 1;
      SH_RL:   shift_next = shreg >> 1;
      default: shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
    endcase
  end

  assign iterate  = is_shift && (shamt != 5'd0) && !FAST_SHIFT;
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      sh_kind_q <= SH_LL;
    end else if (accept) begin
      if (iterate) begin
        state     <= SHIFT;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        shreg     <= rt_content;
        cnt       <= shamt;
        sh_kind_q <= sh_kind;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= calc_result;
        ovf       <= calc_ovf;
        err       <= calc_err;
      end
    end else begin
      case (state)
        SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= shift_next;
            ovf       <= 1'b0;
            err       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Bench for mips_alu_seq: 32-bit iterative and 64-bit barrel instances, each
// checked every cycle against an arithmetic model with a handshake-driven scoreboard.
module tb_mips_alu_seq;

  typedef struct {
    logic [63:0] r;
    logic        o;
    logic        e;
    longint      vcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [2] = '{1'b0, 1'b0};
  logic        ordy [2] = '{1'b1, 1'b1};
  logic        ir [2], ov [2], bsy [2], of [2], ef [2];
  logic [31:0] instr [2] = '{32'h0, 32'h0};
  logic [63:0] ra [2] = '{64'h0, 64'h0};
  logic [63:0] rb [2] = '{64'h0, 64'h0};
  logic [31:0] res0;
  logic [63:0] res1;

  int     ordy_mode [2] = '{1, 1};
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     front_seen [2] = '{1'b0, 1'b0};
  exp_t   q [2][$];

  mips_alu_seq #(.WIDTH(32), .FAST_SHIFT(1'b0)) u_seq32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .input_instruction(instr[0]), .rs_content(ra[0][31:0]), .rt_content(rb[0][31:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res0), .ovf(of[0]), .err(ef[0]),
    .busy(bsy[0])
  );

  mips_alu_seq #(.WIDTH(64), .FAST_SHIFT(1'b1)) u_fast64 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .input_instruction(instr[1]), .rs_content(ra[1]), .rt_content(rb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res1), .ovf(of[1]), .err(ef[1]),
    .busy(bsy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      ordy[d] = (ordy_mode[d] == 2) ? ($urandom_range(0, 3) != 0) : (ordy_mode[d] == 1);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic string nm(input int d, input string s);
    return $sformatf("dut%0d_%s", d, s);
  endfunction

  function automatic bit add_ovf(input int w, input longint x, input longint y, input bit sub);
    longint t;
    t = sub ? x - y : x + y;
    if (w == 32) return (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return sub ? ((x[63] != y[63]) && (t[63] != x[63])) : ((x[63] == y[63]) && (t[63] != x[63]));
  endfunction

  // Reference ALU: operands held as sign-correct 64-bit integers, results masked to w bits.
  function automatic void model(input int w, input logic [31:0] ins, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] r,
                                output logic o, output logic e);
    logic [63:0] mask, a, b, zx, ui;
    longint      sa, sb, si;
    int          sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = (w == 64) ? longint'(a) : longint'($signed(a[31:0]));
    sb = (w == 64) ? longint'(b) : longint'($signed(b[31:0]));
    si = longint'($signed(ins[15:0]));
    zx = {48'h0, ins[15:0]};
    ui = si & mask;
    sh = int'(ins[10:6]);
    r = '0; o = 1'b0; e = 1'b0;
    case (ins[31:26])
      6'd0: begin
        case (ins[5:0])
          6'd32: begin r = (a + b) & mask; o = add_ovf(w, sa, sb, 1'b0); end
          6'd34: begin r = (a - b) & mask; o = add_ovf(w, sa, sb, 1'b1); end
          6'd36: r = a & b;
          6'd37: r = a | b;
          6'd42: r = {63'h0, sa < sb};
          6'd43: r = {63'h0, a < b};
          6'd0:  r = (b << sh) & mask;
          6'd2:  r = b >> sh;
          6'd3:  r = 64'(sb >>> sh) & mask;
          default: e = 1'b1;
        endcase
      end
      6'd8:  begin r = (a + ui) & mask; o = add_ovf(w, sa, si, 1'b0); end
      6'd9:  r = (a + ui) & mask;
      6'd10: r = {63'h0, sa < si};
      6'd11: r = {63'h0, a < ui};
      6'd12: r = a & zx;
      6'd13: r = a | zx;
      6'd15: r = (zx << 16) & mask;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic int extra_cycles(input logic [31:0] ins, input bit fast);
    bit sh_op;
    sh_op = (ins[31:26] == 6'd0) && (ins[5:0] == 6'd0 || ins[5:0] == 6'd2 || ins[5:0] == 6'd3);
    return (sh_op && !fast) ? int'(ins[10:6]) : 0;
  endfunction

  task automatic mon(input int d, input int w, input bit fast, input logic v, input logic rdy,
                     input logic bz, input logic ordv, input logic ivv, input logic [63:0] res,
                     input logic o, input logic e, input logic [31:0] ins,
                     input logic [63:0] a, input logic [63:0] b);
    exp_t x;
    bit   empty;
    if (rst) begin
      check(nm(d, "rst_out_valid"), v, 0);
      check(nm(d, "rst_in_ready"), rdy, 0);
      check(nm(d, "rst_busy"), bz, 0);
      check(nm(d, "rst_result"), res, 0);
      return;
    end
    empty = (q[d].size() == 0);
    check(nm(d, "in_ready"), rdy, empty || (v && ordv));
    check(nm(d, "busy"), bz, !empty && !v);
    if (v) begin
      if (empty) check(nm(d, "spurious_out_valid"), v, 0);
      else begin
        x = q[d][0];
        check(nm(d, "result"), res, x.r);
        check(nm(d, "ovf"), o, x.o);
        check(nm(d, "err"), e, x.e);
        if (!front_seen[d]) check(nm(d, "latency_cycle"), cyc, x.vcyc);
        front_seen[d] = 1'b1;
        if (ordv) begin
          void'(q[d].pop_front());
          front_seen[d] = 1'b0;
        end
      end
    end
    if (ivv && rdy) begin
      model(w, ins, a, b, x.r, x.o, x.e);
      x.vcyc = cyc + 1 + extra_cycles(ins, fast);
      q[d].push_back(x);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, 1'b0, ov[0], ir[0], bsy[0], ordy[0], iv[0], {32'h0, res0}, of[0], ef[0],
        instr[0], ra[0], rb[0]);
    mon(1, 64, 1'b1, ov[1], ir[1], bsy[1], ordy[1], iv[1], res1, of[1], ef[1],
        instr[1], ra[1], rb[1]);
  end

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'd0, 10'd0, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [9] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd43, 6'd0, 6'd2, 6'd3};
    logic [5:0]  ops [7] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd15};
    logic [31:0] ins;
    int          k;
    k   = $urandom_range(0, 19);
    ins = $urandom;
    if (k < 9) begin ins[31:26] = 6'd0; ins[5:0] = fns[k]; end
    else if (k < 16) ins[31:26] = ops[k-9];
    else if (k < 18) begin ins[31:26] = 6'd0; ins[5:0] = 6'd1; end
    else ins[31:26] = 6'h3F;
    return ins;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h0000_0000_7FFF_FFFF;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int d, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
    iv[d] = 1'b1; instr[d] = ins; ra[d] = a; rb[d] = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ir[d]) break;
      if (t > 400) begin
        n_checks++; n_fail++;
        $display("FAIL %s: got no in_ready within 400 cycles, required accept", nm(d, "send_timeout"));
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int d);
    iv[d] = 1'b0;
    ordy_mode[d] = 1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (q[d].size() == 0 && !ov[d]) break;
      if (t > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL %s: got %0d pending results, required 0", nm(d, "drain_timeout"), q[d].size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input int w, input logic [31:0] ins, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] er, input logic eo, input logic ee);
    logic [63:0] r;
    logic        o, e;
    model(w, ins, a, b, r, o, e);
    check({"model_", name}, {r, o, e}, {er, eo, ee});
  endtask

  initial begin
    int nb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_0", {ov[0], bsy[0], of[0], ef[0], ir[0], res0}, 0);
    check("reset_state_1", {ov[1], bsy[1], of[1], ef[1], ir[1], res1}, 0);
    rst = 1'b0;

    pin("add_ovf", 32, rtype(6'd32, 5'd0), 64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 1'b1, 1'b0);
    pin("addiu", 32, itype(6'd9, 16'hFFFF), 64'h5, 64'h0, 64'h4, 1'b0, 1'b0);
    pin("sra4", 32, rtype(6'd3, 5'd4), 64'h0, 64'h8000_0000, 64'hF800_0000, 1'b0, 1'b0);
    pin("srl4", 32, rtype(6'd2, 5'd4), 64'h0, 64'h8000_0000, 64'h0800_0000, 1'b0, 1'b0);
    pin("slti", 32, itype(6'd10, 16'h0001), 64'hFFFF_FFFF, 64'h0, 64'h1, 1'b0, 1'b0);
    pin("sltu", 32, rtype(6'd43, 5'd0), 64'hFFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b0);
    pin("andi", 32, itype(6'd12, 16'h8000), 64'hFFFF_FFFF, 64'h0, 64'h8000, 1'b0, 1'b0);
    pin("lui", 32, itype(6'd15, 16'h1234), 64'h0, 64'h0, 64'h1234_0000, 1'b0, 1'b0);
    pin("illegal", 32, itype(6'h3F, 16'h0), 64'h5, 64'h5, 64'h0, 1'b0, 1'b1);
    pin("sll64", 64, rtype(6'd0, 5'd31), 64'h0, 64'h1, 64'h8000_0000, 1'b0, 1'b0);

    // Back-to-back single-cycle ops and the plan's shifts on the iterative instance.
    send(0, rtype(6'd32, 5'd0), 64'h7FFF_FFFF, 64'h1);
    send(0, itype(6'd9, 16'hFFFF), 64'h5, 64'h0);
    send(0, itype(6'd10, 16'h0001), 64'hFFFF_FFFF, 64'h0);
    send(0, rtype(6'd43, 5'd0), 64'hFFFF_FFFF, 64'h1);
    send(0, itype(6'd12, 16'h8000), 64'hFFFF_FFFF, 64'h0);
    send(0, itype(6'd15, 16'h1234), 64'h0, 64'h0);
    send(0, itype(6'h3F, 16'h0), 64'h1, 64'h2);
    send(0, rtype(6'd2, 5'd4), 64'h0, 64'h8000_0000);
    send(0, rtype(6'd0, 5'd31), 64'h0, 64'h1);
    drain(0);

    send(0, rtype(6'd3, 5'd4), 64'h0, 64'h8000_0000);
    iv[0] = 1'b0;
    nb = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ov[0]) break;
      if (bsy[0]) nb++;
    end
    check("sra4_busy_cycles", nb, 4);
    check("sra4_result", {32'h0, res0}, 64'hF800_0000);
    @(posedge clk); #1;
    drain(0);

    // Back-pressure: result frozen and no accept while the consumer stalls.
    ordy_mode[0] = 0;
    @(posedge clk); #1;
    send(0, rtype(6'd32, 5'd0), 64'h7FFF_FFFF, 64'h1);
    instr[0] = itype(6'd13, 16'h00F0);
    ra[0] = 64'h0000_0F00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", {of[0], res0}, {1'b1, 32'h8000_0000});
      check("bp_in_ready", {ov[0], ir[0]}, 2'b10);
    end
    @(posedge clk); #1;
    ordy_mode[0] = 1;
    send(0, itype(6'd13, 16'h00F0), 64'h0000_0F00, 64'h0);
    drain(0);

    // Reset in the middle of a long shift discards the transaction.
    send(0, rtype(6'd0, 5'd20), 64'h0, 64'h3);
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    q[0].delete(); front_seen[0] = 1'b0;
    #1;
    check("midshift_rst_outputs", {ov[0], bsy[0], of[0], ef[0], ir[0], res0}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {ir[0], ov[0]}, 2'b10);
    @(posedge clk); #1;

    ordy_mode[0] = 2;
    for (int i = 0; i < 150; i++) begin
      send(0, rand_instr(), rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) begin
        iv[0] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain(0);

    // 64-bit barrel instance.
    send(1, rtype(6'd0, 5'd31), 64'h0, 64'h1);
    iv[1] = 1'b0;
    @(negedge clk);
    check("fast64_sll31", {ov[1], res1}, {1'b1, 64'h0000_0000_8000_0000});
    @(posedge clk); #1;
    drain(1);
    ordy_mode[1] = 2;
    for (int i = 0; i < 200; i++) begin
      send(1, rand_instr(), rand_op(), rand_op());
      if ($urandom_range(0, 4) == 0) begin
        iv[1] = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
